// File: rtl/up_sampler.sv
// up_sampler
//   Reader end of the Gaussian output FIFO. Pops filtered pixels (row-major,
//   IN_WIDTH x IN_HEIGHT) and emits a 2x nearest-neighbour upsampled stream
//   (2*IN_WIDTH x 2*IN_HEIGHT). Every pixel is sent twice horizontally. Every
//   line is written into a line buffer while it streams out and is then replayed
//   once, so it also appears twice vertically.
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   empty      in   upstream FIFO empty
//   rd_en_up   out  FIFO pop request, one-cycle pulse
//   valid      in   FIFO read data valid, one cycle after rd_en_up
//   din        in   FIFO read data
//   valid_out  out  output pixel valid
//   dout       out  output pixel
//   ready      in   downstream accepts dout when valid_out & ready
//   frame_done out  one-cycle pulse after the last pixel of a frame is accepted
//   err        out  only with UPSAMPLE_ERR_EN: sticky protocol-violation flag
//
// Build option
//   UPSAMPLE_ERR_EN  adds the err port. It sets on a stray valid (no read
//                    pending) or on a pop request while empty. Only rst clears it.
module up_sampler #(
  parameter int IN_WIDTH  = 400,
  parameter int IN_HEIGHT = 300,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd_en_up,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout,
  input  logic              ready,
  output logic              frame_done
`ifdef UPSAMPLE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              dup_q, dup_d;
  logic              pend_q, pend_d;
  logic              load_q, load_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] linebuf_q [IN_WIDTH];
  logic [DATA_W-1:0] rdata_q;

  logic accept;
  logic last_col;
  logic last_row;
  logic rd_en;
  logic capture;

  assign accept   = valid_out_q & ready;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  // State register and output registers. The line buffer is kept out of this
  // block so that it maps onto a plain synchronous RAM without reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      dup_q        <= 1'b0;
      pend_q       <= 1'b0;
      load_q       <= 1'b0;
      valid_out_q  <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      dup_q        <= dup_d;
      pend_q       <= pend_d;
      load_q       <= load_d;
      valid_out_q  <= valid_out_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic. col always names the pixel that is in flight, in the
  // output register, or next to fetch. It advances when the second copy of a
  // pixel is accepted.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    dup_d        = dup_q;
    pend_d       = pend_q;
    load_d       = 1'b0;
    valid_out_d  = valid_out_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        // Only pop when the output register frees up. The final pixel of the
        // line must not trigger a read, because the line is replayed next.
        rd_en = ~empty & ~pend_q &
                (~valid_out_q | (accept & dup_q & ~last_col));
        if (rd_en) begin
          pend_d = 1'b1;
        end
        if (pend_q & valid) begin
          capture     = 1'b1;
          pend_d      = 1'b0;
          dout_d      = din;
          valid_out_d = 1'b1;
          dup_d       = 1'b0;
        end
        if (accept) begin
          if (!dup_q) begin
            dup_d = 1'b1;
          end else begin
            valid_out_d = 1'b0;
            dup_d       = 1'b0;
            if (last_col) begin
              col_d   = '0;
              state_d = REPLAY;
              load_d  = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      REPLAY: begin
        // load_q marks the cycle after a buffer read was issued at address col_d.
        if (load_q) begin
          dout_d      = rdata_q;
          valid_out_d = 1'b1;
          dup_d       = 1'b0;
        end
        if (accept) begin
          if (!dup_q) begin
            dup_d = 1'b1;
          end else begin
            valid_out_d = 1'b0;
            dup_d       = 1'b0;
            if (last_col) begin
              col_d = '0;
              if (last_row) begin
                row_d        = '0;
                state_d      = IDLE;
                frame_done_d = 1'b1;
              end else begin
                row_d   = row_q + ROW_W'(1);
                state_d = FETCH;
              end
            end else begin
              col_d  = col_q + COL_W'(1);
              load_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line buffer with one-cycle read latency. The read address is col_d, so
  // the entry for the next replay pixel is fetched on the same edge col advances.
  always_ff @(posedge clk) begin
    if (capture) begin
      linebuf_q[col_q] <= din;
    end
    rdata_q <= linebuf_q[col_d];
  end

`ifdef UPSAMPLE_ERR_EN
  logic err_q;

  // Sticky protocol-violation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((valid & ~pend_q) | (rd_en & empty)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign rd_en_up   = rd_en;
  assign valid_out  = valid_out_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_up_sampler.sv
// tb_up_sampler
//   Scoreboard bench for up_sampler at IN_WIDTH=4, IN_HEIGHT=2. A queue-based
//   FIFO model feeds the DUT. Expected upsampled beats are queued when a frame
//   is loaded and are popped as the DUT hands each beat downstream.
module tb_up_sampler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          empty;
  logic          rd_en_up;
  logic          valid;
  logic [DW-1:0] din;
  logic          valid_out;
  logic [DW-1:0] dout;
  logic          ready = 1'b1;
  logic          frame_done;
`ifdef UPSAMPLE_ERR_EN
  logic          err;
`endif

  logic          fifoValid  = 1'b0;
  logic          fifoEmpty  = 1'b1;
  logic [DW-1:0] fifoDin    = '0;
  logic          strayValid = 1'b0;
  logic [DW-1:0] strayDin   = '0;
  logic          randReady  = 1'b0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] expQ[$];
  bit            expLast[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int beats       = 0;
  int fdCount     = 0;
  bit prevHeld     = 1'b0;
  bit lastWasFinal = 1'b0;
  logic [DW-1:0] prevDout = '0;

  assign empty = fifoEmpty;
  assign valid = fifoValid | strayValid;
  assign din   = strayValid ? strayDin : fifoDin;

  up_sampler #(
    .IN_WIDTH (W),
    .IN_HEIGHT(H),
    .DATA_W   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .rd_en_up  (rd_en_up),
    .valid     (valid),
    .din       (din),
    .valid_out (valid_out),
    .dout      (dout),
    .ready     (ready),
    .frame_done(frame_done)
`ifdef UPSAMPLE_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: registered read data, valid one cycle after the pop.
  always @(posedge clk) begin
    if (rd_en_up === 1'b1 && fifoQ.size() > 0) begin
      fifoDin   <= fifoQ.pop_front();
      fifoValid <= 1'b1;
    end else begin
      fifoValid <= 1'b0;
    end
    fifoEmpty <= (fifoQ.size() == 0);
  end

  // Random downstream backpressure while randReady is set.
  always @(posedge clk) begin
    #1;
    if (randReady) ready = 1'($urandom_range(0, 1));
  end

  // Output monitor. It samples mid-cycle, checks each accepted beat against the
  // scoreboard, checks hold stability under backpressure, checks frame_done
  // placement, and checks that no pop is requested while the FIFO is empty.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    bit l;
    if (rst) begin
      prevHeld     = 1'b0;
      lastWasFinal = 1'b0;
    end else begin
      if (prevHeld) begin
        testsRun++;
        if (valid_out !== 1'b1 || dout !== prevDout) begin
          testsFailed++;
          $display("[TB] FAIL hold_stable: valid_out=%b dout=%0d, required valid_out=1 dout=%0d",
                   valid_out, dout, prevDout);
        end
      end
      if (lastWasFinal) begin
        testsRun++;
        if (frame_done !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL frame_done_pulse: got %b, required 1", frame_done);
        end
      end else if (frame_done !== 1'b0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL frame_done_spurious: got %b, required 0", frame_done);
      end
      if (frame_done === 1'b1) fdCount++;
      if (rd_en_up === 1'b1) begin
        testsRun++;
        if (empty !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL rd_while_empty: empty=%b, required 0 when rd_en_up=1", empty);
        end
      end
      lastWasFinal = 1'b0;
      if (valid_out === 1'b1 && ready === 1'b1) begin
        beats++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_beat: dout=%0d, required no beat", dout);
        end else begin
          e = expQ.pop_front();
          l = expLast.pop_front();
          if (dout !== e) begin
            testsFailed++;
            $display("[TB] FAIL beat_data: dout=%0d, required %0d (beat %0d)", dout, e, beats);
          end
          lastWasFinal = l;
        end
      end
      prevHeld = (valid_out === 1'b1 && ready === 1'b0);
      prevDout = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifoPush(input int v);
    fifoQ.push_back(DW'(v));
    fifoEmpty = 1'b0;
  endtask

  // Queue the expected upsampled beats for a frame of consecutive pixel values.
  task automatic expectFrame(input int first);
    for (int r = 0; r < H; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < W; c++)
          for (int d = 0; d < 2; d++) begin
            expQ.push_back(DW'(first + r * W + c));
            expLast.push_back(r == H - 1 && rep == 1 && c == W - 1 && d == 1);
          end
  endtask

  task automatic waitBeats(input int target, input int maxCycles, input string what);
    int n = 0;
    while (beats < target && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    testsRun++;
    if (beats < target) begin
      testsFailed++;
      $display("[TB] FAIL timeout_%s: beats=%0d, required %0d", what, beats, target);
    end
  endtask

  task automatic checkFrameEnd(input int startFd, input int frames, input string what);
    repeat (3) tick();
    testsRun++;
    if (fdCount - startFd !== frames) begin
      testsFailed++;
      $display("[TB] FAIL frame_done_count_%s: got %0d, required %0d", what, fdCount - startFd, frames);
    end
    testsRun++;
    if (expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL leftover_%s: %0d beats missing, required 0", what, expQ.size());
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) tick();
    testsRun++;
    if (rd_en_up !== 1'b0 || valid_out !== 1'b0 || frame_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: rd_en_up=%b valid_out=%b frame_done=%b, required 000",
               rd_en_up, valid_out, frame_done);
    end
    testsRun++;
    if (dout !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_dout: got %0d, required 0", dout);
    end
`ifdef UPSAMPLE_ERR_EN
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_err: got %b, required 0", err);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int startB = beats;
    int startFd = fdCount;
    int n = 0;
    expectFrame(1);
    for (int i = 1; i <= 8; i++) fifoPush(i);
    while (rd_en_up !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    testsRun++;
    if (rd_en_up !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL first_read: rd_en_up=%b, required 1", rd_en_up);
    end
    @(negedge clk);
    #1;
    testsRun++;
    if (valid_out !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL latency_early: valid_out=%b, required 0", valid_out);
    end
    @(negedge clk);
    #1;
    testsRun++;
    if (valid_out !== 1'b1 || dout !== 8'd1) begin
      testsFailed++;
      $display("[TB] FAIL latency_two: valid_out=%b dout=%0d, required 1 and 1", valid_out, dout);
    end
    waitBeats(startB + 32, 300, "basic");
    checkFrameEnd(startFd, 1, "basic");
  endtask

  task automatic test_random_ready();
    int startB = beats;
    int startFd = fdCount;
    expectFrame(1);
    for (int i = 1; i <= 8; i++) fifoPush(i);
    randReady = 1'b1;
    waitBeats(startB + 32, 1500, "random_ready");
    randReady = 1'b0;
    tick();
    ready = 1'b1;
    checkFrameEnd(startFd, 1, "random_ready");
  endtask

  task automatic test_empty_stall();
    int startB = beats;
    int startFd = fdCount;
    expectFrame(1);
    fifoPush(1);
    fifoPush(2);
    repeat (25) tick();
    testsRun++;
    if (beats - startB !== 4) begin
      testsFailed++;
      $display("[TB] FAIL stall_beats: got %0d, required 4", beats - startB);
    end
    testsRun++;
    if (valid_out !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_valid: got %b, required 0", valid_out);
    end
    for (int i = 3; i <= 8; i++) fifoPush(i);
    waitBeats(startB + 32, 300, "stall");
    checkFrameEnd(startFd, 1, "stall");
  endtask

  task automatic test_reset_mid_replay();
    int startB = beats;
    int startFd;
    expectFrame(1);
    for (int i = 1; i <= 8; i++) fifoPush(i);
    waitBeats(startB + 10, 300, "pre_reset");
    rst = 1'b1;
    #1;
    testsRun++;
    if (valid_out !== 1'b0 || dout !== '0 || rd_en_up !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: valid_out=%b dout=%0d rd_en_up=%b, required 0 0 0",
               valid_out, dout, rd_en_up);
    end
    expQ.delete();
    expLast.delete();
    repeat (3) tick();
    testsRun++;
    if (fifoQ.size() !== 4) begin
      testsFailed++;
      $display("[TB] FAIL replay_no_pop: fifo holds %0d, required 4", fifoQ.size());
    end
    startB  = beats;
    startFd = fdCount;
    expectFrame(5);
    for (int i = 9; i <= 12; i++) fifoPush(i);
    rst = 1'b0;
    waitBeats(startB + 32, 300, "after_reset");
    checkFrameEnd(startFd, 1, "after_reset");
  endtask

  task automatic test_stray_valid();
    int startB = beats;
    tick();
    strayDin   = 8'hAA;
    strayValid = 1'b1;
    tick();
    strayValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if (valid_out !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL stray_valid_out: got %b, required 0", valid_out);
      end
    end
    testsRun++;
    if (beats !== startB) begin
      testsFailed++;
      $display("[TB] FAIL stray_beats: got %0d, required %0d", beats, startB);
    end
`ifdef UPSAMPLE_ERR_EN
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stray_err: got %b, required 1", err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int startB = beats;
    int startFd = fdCount;
    expectFrame(20);
    expectFrame(28);
    for (int i = 20; i <= 35; i++) fifoPush(i);
    waitBeats(startB + 64, 600, "back_to_back");
    checkFrameEnd(startFd, 2, "back_to_back");
`ifdef UPSAMPLE_ERR_EN
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err_sticky: got %b, required 1", err);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_clear: got %b, required 0", err);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_ready();
    test_empty_stall();
    test_reset_mid_replay();
    test_stray_valid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
